// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map, register offsets and response-source encoding
package mem_map_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE_ADDR = 32'h8000_0000;

  localparam logic [2:0] REG_TIMER_SET    = 3'd0;
  localparam logic [2:0] REG_TIMER_STATUS = 3'd1;
  localparam logic [2:0] REG_GPIO_OUT     = 3'd2;
  localparam logic [2:0] REG_GPIO_OE      = 3'd3;
  localparam logic [2:0] REG_GPIO_IN      = 3'd4;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_SRAM,
    RESP_MMIO,
    RESP_ERR
  } resp_src_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - two-flop synchronizer for asynchronous GPIO pad inputs
module gpio_in_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - single-cycle responder decoding requests to SRAM, timer and GPIO
module mem_bus_responder #(
  parameter logic [31:0] SRAM_BASE = mem_map_pkg::SRAM_BASE_ADDR,
  parameter int          SRAM_AW   = 14,
  parameter logic [31:0] MMIO_BASE = mem_map_pkg::MMIO_BASE_ADDR,
  parameter int          GPIO_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_i,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [3:0]         mem_be_i,
  input  logic [31:0]        mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic               mem_err_o,
  output logic [31:0]        mem_rdata_o,
  output logic               sram_req_o,
  output logic               sram_we_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [3:0]         sram_be_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i,
  output logic [31:0]        timer_set_val_o,
  output logic               set_timer_o,
  input  logic               timer_is_high_i,
  output logic [GPIO_W-1:0]  gpio_o,
  output logic [GPIO_W-1:0]  gpio_oe_o,
  input  logic [GPIO_W-1:0]  gpio_i
);

  import mem_map_pkg::*;

  localparam logic [32:0] SRAM_BYTES = 33'd4 << SRAM_AW;

  logic [31:0]       sram_off;
  logic              sram_hit;
  logic              mmio_hit;
  logic [2:0]        reg_off;
  logic [GPIO_W-1:0] gpio_sync;
  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] gpio_oe_q;
  logic [31:0]       timer_val_q;
  logic              set_timer_q;
  logic              wr_timer;
  logic              wr_gpio_out;
  logic              wr_gpio_oe;
  resp_src_e         resp_src_q;
  resp_src_e         resp_src_d;
  logic [31:0]       resp_rdata_q;
  logic [31:0]       resp_rdata_d;

  gpio_in_sync #(.W(GPIO_W)) u_gpio_in_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_i),
    .q   (gpio_sync)
  );

  assign sram_off = mem_addr_i - SRAM_BASE;
  assign sram_hit = {1'b0, sram_off} < SRAM_BYTES;
  assign mmio_hit = mem_addr_i[31:5] == MMIO_BASE[31:5];
  assign reg_off  = mem_addr_i[4:2];

  assign sram_req_o   = rst & mem_req_i & sram_hit;
  assign sram_we_o    = sram_req_o & mem_we_i;
  assign sram_addr_o  = rst ? sram_off[SRAM_AW+1:2] : '0;
  assign sram_be_o    = rst ? mem_be_i : '0;
  assign sram_wdata_o = rst ? mem_wdata_i : '0;

  // SRAM writes are reported as MMIO with zero captured data so rdata reads 0
  // without widening the response-source state.
  always_comb begin
    resp_src_d   = RESP_NONE;
    resp_rdata_d = '0;
    wr_timer     = 1'b0;
    wr_gpio_out  = 1'b0;
    wr_gpio_oe   = 1'b0;
    if (mem_req_i) begin
      if (sram_hit) begin
        resp_src_d = mem_we_i ? RESP_MMIO : RESP_SRAM;
      end else if (mmio_hit) begin
        resp_src_d = RESP_MMIO;
        case (reg_off)
          REG_TIMER_SET: begin
            if (mem_we_i) wr_timer = 1'b1;
            else          resp_rdata_d = timer_val_q;
          end
          REG_TIMER_STATUS: begin
            if (mem_we_i) resp_src_d = RESP_ERR;
            else          resp_rdata_d = {31'b0, timer_is_high_i};
          end
          REG_GPIO_OUT: begin
            if (mem_we_i) wr_gpio_out = 1'b1;
            else          resp_rdata_d = 32'(gpio_out_q);
          end
          REG_GPIO_OE: begin
            if (mem_we_i) wr_gpio_oe = 1'b1;
            else          resp_rdata_d = 32'(gpio_oe_q);
          end
          REG_GPIO_IN: begin
            if (mem_we_i) resp_src_d = RESP_ERR;
            else          resp_rdata_d = 32'(gpio_sync);
          end
          default: resp_src_d = RESP_ERR;
        endcase
      end else begin
        resp_src_d = RESP_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_src_q   <= RESP_NONE;
      resp_rdata_q <= '0;
      timer_val_q  <= '0;
      set_timer_q  <= 1'b0;
      gpio_out_q   <= '0;
      gpio_oe_q    <= '0;
    end else begin
      resp_src_q   <= resp_src_d;
      resp_rdata_q <= resp_rdata_d;
      set_timer_q  <= wr_timer & (|mem_be_i);
      if (wr_timer)    timer_val_q <= be_merge(timer_val_q, mem_wdata_i, mem_be_i);
      if (wr_gpio_out) gpio_out_q  <= GPIO_W'(be_merge(32'(gpio_out_q), mem_wdata_i, mem_be_i));
      if (wr_gpio_oe)  gpio_oe_q   <= GPIO_W'(be_merge(32'(gpio_oe_q), mem_wdata_i, mem_be_i));
    end
  end

  assign mem_rvalid_o    = resp_src_q != RESP_NONE;
  assign mem_err_o       = resp_src_q == RESP_ERR;
  assign mem_rdata_o     = (resp_src_q == RESP_SRAM) ? sram_rdata_i : resp_rdata_q;
  assign timer_set_val_o = timer_val_q;
  assign set_timer_o     = set_timer_q;
  assign gpio_o          = gpio_out_q;
  assign gpio_oe_o       = gpio_oe_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

  localparam logic [31:0] MMIO = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_rvalid;
  logic        mem_err;
  logic [31:0] mem_rdata;
  logic        sram_req;
  logic        sram_we;
  logic [13:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic [31:0] timer_set_val;
  logic        set_timer;
  logic        timer_is_high = 1'b0;
  logic [9:0]  gpio;
  logic [9:0]  gpio_oe;
  logic [9:0]  gpio_in = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram_mem [0:16383];

  mem_bus_responder dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_i       (mem_req),
    .mem_addr_i      (mem_addr),
    .mem_we_i        (mem_we),
    .mem_be_i        (mem_be),
    .mem_wdata_i     (mem_wdata),
    .mem_rvalid_o    (mem_rvalid),
    .mem_err_o       (mem_err),
    .mem_rdata_o     (mem_rdata),
    .sram_req_o      (sram_req),
    .sram_we_o       (sram_we),
    .sram_addr_o     (sram_addr),
    .sram_be_o       (sram_be),
    .sram_wdata_o    (sram_wdata),
    .sram_rdata_i    (sram_rdata),
    .timer_set_val_o (timer_set_val),
    .set_timer_o     (set_timer),
    .timer_is_high_i (timer_is_high),
    .gpio_o          (gpio),
    .gpio_oe_o       (gpio_oe),
    .gpio_i          (gpio_in)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) sram_mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    mem_req = 1'b1; mem_addr = a; mem_we = we; mem_be = be; mem_wdata = wd;
  endtask

  task automatic idle();
    mem_req = 1'b0; mem_addr = '0; mem_we = 1'b0; mem_be = '0; mem_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(32'h0000_0100, 1'b1, 4'hF, 32'hFFFF_FFFF);
    step();
    #1;
    checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", mem_rvalid); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_gate: got %b expected 0", sram_req); end
    checks++; if (gpio !== 10'h0 || gpio_oe !== 10'h0) begin errors++; $display("FAIL reset_gpio: got %h/%h expected 0/0", gpio, gpio_oe); end
    checks++; if (set_timer !== 1'b0 || timer_set_val !== 32'h0) begin errors++; $display("FAIL reset_timer: got %b/%h expected 0/0", set_timer, timer_set_val); end
    checks++; if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got %h/%b expected 0/0", mem_rdata, mem_err); end
    idle();
    step();
    rst = 1'b1;
  endtask

  task automatic test_first_read();
    drive(MMIO + 32'h8, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL first_read_valid: got rvalid=%b err=%b expected 1/0", mem_rvalid, mem_err); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL first_read_data: got %h expected 0", mem_rdata); end
    checks++; if (gpio_oe !== 10'h0) begin errors++; $display("FAIL first_read_oe: got %h expected 0", gpio_oe); end
    idle();
    step();
    checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b expected 0", mem_rvalid); end
  endtask

  task automatic test_gpio_out();
    drive(MMIO + 32'h8, 1'b1, 4'b0011, 32'h0000_0155);
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL gpio_wr_resp: got v=%b e=%b d=%h expected 1/0/0", mem_rvalid, mem_err, mem_rdata); end
    checks++; if (gpio !== 10'h155) begin errors++; $display("FAIL gpio_wr_value: got %h expected 155", gpio); end
    drive(MMIO + 32'h8, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rdata !== 32'h155) begin errors++; $display("FAIL gpio_rd_value: got %h expected 155", mem_rdata); end
    // Only byte 0 written: bits 9:8 keep 2'b01 from the previous write.
    drive(MMIO + 32'h8, 1'b1, 4'b0001, 32'hFFFF_FF00);
    step();
    checks++; if (gpio !== 10'h100) begin errors++; $display("FAIL gpio_be_partial: got %h expected 100", gpio); end
    drive(MMIO + 32'hC, 1'b1, 4'b0010, 32'hFFFF_FFFF);
    step();
    checks++; if (gpio_oe !== 10'h300) begin errors++; $display("FAIL gpio_oe_wr: got %h expected 300", gpio_oe); end
    drive(MMIO + 32'hC, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rdata !== 32'h300) begin errors++; $display("FAIL gpio_oe_rd: got %h expected 300", mem_rdata); end
    idle();
  endtask

  task automatic test_timer();
    drive(MMIO, 1'b1, 4'hF, 32'h0000_1234);
    step();
    checks++; if (set_timer !== 1'b1 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL timer_pulse: got set=%b rvalid=%b expected 1/1", set_timer, mem_rvalid); end
    checks++; if (timer_set_val !== 32'h1234) begin errors++; $display("FAIL timer_val: got %h expected 1234", timer_set_val); end
    idle();
    step();
    checks++; if (set_timer !== 1'b0) begin errors++; $display("FAIL timer_pulse_len: got %b expected 0", set_timer); end
    drive(MMIO, 1'b1, 4'h0, 32'hFFFF_FFFF);
    step();
    checks++; if (set_timer !== 1'b0 || timer_set_val !== 32'h1234) begin errors++; $display("FAIL timer_be0: got set=%b val=%h expected 0/1234", set_timer, timer_set_val); end
    checks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL timer_be0_resp: got v=%b e=%b expected 1/0", mem_rvalid, mem_err); end
    timer_is_high = 1'b1;
    drive(MMIO + 32'h4, 1'b0, 4'hF, 32'h0);
    step();
    timer_is_high = 1'b0;
    checks++; if (mem_rdata !== 32'h1 || mem_err !== 1'b0) begin errors++; $display("FAIL timer_status: got %h/%b expected 1/0", mem_rdata, mem_err); end
    drive(MMIO, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rdata !== 32'h1234) begin errors++; $display("FAIL timer_readback: got %h expected 1234", mem_rdata); end
    idle();
  endtask

  task automatic test_sram();
    drive(32'h0000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    #1;
    checks++; if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 14'h40) begin errors++; $display("FAIL sram_wr_cmd: got req=%b we=%b addr=%h expected 1/1/40", sram_req, sram_we, sram_addr); end
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL sram_wr_resp: got v=%b e=%b d=%h expected 1/0/0", mem_rvalid, mem_err, mem_rdata); end
    drive(32'h0000_0100, 1'b0, 4'hF, 32'h0);
    #1;
    checks++; if (sram_req !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 14'h40) begin errors++; $display("FAIL sram_rd_cmd: got req=%b we=%b addr=%h expected 1/0/40", sram_req, sram_we, sram_addr); end
    step();
    checks++; if (mem_rdata !== 32'hDEAD_BEEF || mem_err !== 1'b0) begin errors++; $display("FAIL sram_rd_data: got %h/%b expected deadbeef/0", mem_rdata, mem_err); end
    // Last SRAM word is still a hit; one past it is unmapped.
    drive(32'h0000_FFFC, 1'b1, 4'hF, 32'h0BAD_F00D);
    #1;
    checks++; if (sram_req !== 1'b1 || sram_addr !== 14'h3FFF) begin errors++; $display("FAIL sram_top_cmd: got req=%b addr=%h expected 1/3fff", sram_req, sram_addr); end
    step();
    drive(32'h0001_0000, 1'b0, 4'hF, 32'h0);
    #1;
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL sram_past_end: got %b expected 0", sram_req); end
    step();
    checks++; if (mem_err !== 1'b1 || mem_rdata !== 32'h0) begin errors++; $display("FAIL sram_past_end_err: got %b/%h expected 1/0", mem_err, mem_rdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(32'h0000_FFFC, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_first: got v=%b d=%h expected 1/0badf00d", mem_rvalid, mem_rdata); end
    drive(MMIO + 32'h8, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'h100) begin errors++; $display("FAIL b2b_second: got v=%b d=%h expected 1/100", mem_rvalid, mem_rdata); end
    drive(32'h4000_0000, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b1) begin errors++; $display("FAIL b2b_third: got v=%b e=%b expected 1/1", mem_rvalid, mem_err); end
    idle();
    step();
  endtask

  task automatic test_errors();
    drive(32'h4000_0000, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_err !== 1'b1 || mem_rdata !== 32'h0 || mem_rvalid !== 1'b1) begin errors++; $display("FAIL err_unmapped: got v=%b e=%b d=%h expected 1/1/0", mem_rvalid, mem_err, mem_rdata); end
    drive(MMIO + 32'h10, 1'b1, 4'hF, 32'hFFFF_FFFF);
    step();
    checks++; if (mem_err !== 1'b1 || mem_rdata !== 32'h0) begin errors++; $display("FAIL err_ro_write: got e=%b d=%h expected 1/0", mem_err, mem_rdata); end
    drive(MMIO + 32'h14, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_offset5: got %b expected 1", mem_err); end
    checks++; if (gpio !== 10'h100 || gpio_oe !== 10'h300) begin errors++; $display("FAIL err_no_change: got %h/%h expected 100/300", gpio, gpio_oe); end
    idle();
  endtask

  task automatic test_gpio_in();
    logic [31:0] resp [3];
    gpio_in = 10'h2AA;
    drive(MMIO + 32'h10, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      resp[i] = mem_rdata;
    end
    idle();
    checks++; if (resp[0] !== 32'h0) begin errors++; $display("FAIL gpio_in_sync_delay: got %h expected 0", resp[0]); end
    checks++; if (resp[2] !== 32'h2AA) begin errors++; $display("FAIL gpio_in_visible: got %h expected 2aa", resp[2]); end
  endtask

  task automatic test_reset_pending();
    drive(MMIO + 32'h8, 1'b0, 4'hF, 32'h0);
    step();
    #1;
    rst = 1'b0;
    #1;
    checks++; if (mem_rvalid !== 1'b0 || gpio !== 10'h0) begin errors++; $display("FAIL rst_async: got v=%b gpio=%h expected 0/0", mem_rvalid, gpio); end
    step();
    checks++; if (mem_rvalid !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b expected 0", mem_rvalid); end
    rst = 1'b1;
    drive(MMIO + 32'h10, 1'b0, 4'hF, 32'h0);
    step();
    checks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL rst_first_req: got v=%b e=%b expected 1/0", mem_rvalid, mem_err); end
    idle();
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_first_read();
    test_gpio_out();
    test_timer();
    test_sram();
    test_back_to_back();
    test_errors();
    test_gpio_in();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
